mul_digit_seq: RTL and testbench
================================

# mul_digit_seq

Sequential WIDTH×WIDTH unsigned multiplier that time-shares one combinational 2-bit×2-bit multiplier core. The block splits each operand into 2-bit digits and feeds one digit pair per cycle to the core. It shifts each partial product into place and accumulates it. It sits between an operand producer and a result consumer, both using valid/ready handshakes, and it owns the sequencing of the small multiplier datapath.

## Interface
- WIDTH, 8, operand width in bits; must be even and ≥ 2. D = WIDTH/2 digits.
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  multiplicand, unsigned.
- b  in  WIDTH  multiplier, unsigned.
- out_valid  out  1  product available.
- out_ready  in  1  consumer takes the product.
- p  out  2*WIDTH  product a*b, unsigned.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM has three states.
  - IDLE: in_ready=1. On in_valid&in_ready, capture a and b into internal registers, clear the accumulator, set digit counters i=j=0, and go to RUN.
  - RUN: each cycle computes pp = core(a_reg[2i+1:2i], b_reg[2j+1:2j]), a 4-bit value with maximum 9. It then updates acc += pp << 2(i+j).
    - j increments every cycle. When j=D-1, j wraps to 0 and i increments.
    - The cycle with i=j=D-1 is the last RUN cycle, and the next state is DONE.
  - DONE: out_valid=1 and p=acc. On out_ready, go to IDLE.
- The accumulator is 2*WIDTH bits. It cannot overflow because the final value is at most (2^WIDTH−1)², so the shift/add needs no saturation.
- During RUN and DONE, in_ready=0. in_valid, a and b are ignored, and the captured operands are not affected by input changes.
- p is held stable while out_valid=1 and out_ready=0.
- p is driven from acc at all times. It is only meaningful while out_valid=1.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, p=0, acc=0, i=j=0.
- Accept edge = E0. RUN lasts exactly D*D cycles, covering E0+1 through E0+D*D. out_valid is first high in cycle E0+D*D+1. With WIDTH=8, that is 16 RUN cycles and out_valid in cycle 17.
- Result handshake completes on the edge where out_valid&out_ready=1. The next cycle is IDLE with in_ready=1.
- Minimum initiation interval is D*D+2 cycles: accept, D*D RUN cycles, one DONE cycle.
- If rst is asserted in any state, the next cycle has all reset values. Any in-flight operation is discarded and no out_valid is produced for it.
- rst has priority over a simultaneous in_valid or out_ready.
- The core is purely combinational. pp is consumed in the same cycle, with no pipeline register.

## Structure
- Package mul_seq_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - DIGIT_W=2 and PP_W=4;
  - a function for the digit count from WIDTH.
- Sub-module mul2x2_core: pure combinational 2-bit×2-bit→4-bit multiplier with ports x[1:0], y[1:0], z[3:0]. It is instantiated once. It is kept separate so it can be swapped for a gate-level netlist in timing runs.
- Top-level contents:
  - FSM;
  - operand registers;
  - i/j counters of $clog2(D) bits, minimum 1;
  - digit muxes;
  - shifter;
  - accumulator.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 → in_ready=1, out_valid=0, busy=0, p=0. No operation starts during reset.
- Max value, WIDTH=8: a=0xFF, b=0xFF accepted at E0 → out_valid first high at E0+17, p=0xFE01. busy is high for E0+1 through E0+17.
- Zero and one: a=0x00, b=0xA5 → p=0x0000. a=0x01, b=0x01 → p=0x0001. Each takes 16 RUN cycles.
- Backpressure: a=0x12, b=0x34, out_ready=0 for 5 cycles after out_valid.
  - p stays 0x03A8 throughout and in_ready stays 0.
  - A new in_valid with a=0x77 during this window is ignored.
  - After out_ready=1, in_ready=1 in the next cycle.
- Reset mid-RUN: accept 0xC3×0x3C and assert rst at E0+7 → cycle E0+8 is IDLE with out_valid=0. A following 0x03×0x07 yields p=0x0015.
- Back-to-back with out_ready tied 1: 0x12×0x34 then 0xC3×0x3C, with in_valid held high.
  - Results are 0x03A8 then 0x2DB4.
  - The second accept occurs exactly 18 cycles after the first.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared types and sizing helpers for the digit-serial multiplier.
package mul_seq_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int unsigned DIGIT_W = 2;
   localparam int unsigned PP_W    = 4;

   function automatic int unsigned digit_count(input int unsigned w);
      return w / DIGIT_W;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned d);
      return (d > 1) ? $clog2(d) : 1;
   endfunction

endpackage

// File: rtl/mul2x2_core.sv
// Purely combinational 2-bit x 2-bit -> 4-bit unsigned multiplier.
module mul2x2_core (
   input  logic [1:0] x,
   input  logic [1:0] y,
   output logic [3:0] z
);

   assign z = {2'b00, x} * {2'b00, y};

endmodule

// File: rtl/mul_digit_seq.sv
// Sequential WIDTH x WIDTH unsigned multiplier, one 2x2 digit product per cycle,
// with valid/ready handshakes on both operand and result sides.
module mul_digit_seq
   import mul_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p,
   output logic               busy
);

   localparam int unsigned D  = digit_count(WIDTH);
   localparam int unsigned CW = cnt_width(D);
   localparam logic [CW-1:0] LAST = CW'(D - 1);

   state_t               state;
   logic [WIDTH-1:0]     a_reg;
   logic [WIDTH-1:0]     b_reg;
   logic [2*WIDTH-1:0]   acc;
   logic [CW-1:0]        i;
   logic [CW-1:0]        j;
   logic [DIGIT_W-1:0]   a_dig;
   logic [DIGIT_W-1:0]   b_dig;
   logic [PP_W-1:0]      pp;
   logic [2*WIDTH-1:0]   pp_sh;

   mul2x2_core u_core (
      .x (a_dig),
      .y (b_dig),
      .z (pp)
   );

   // Digit select and placement: pp lands at bit 2*(i+j) of the accumulator.
   always_comb begin
      a_dig = a_reg[DIGIT_W*int'(i) +: DIGIT_W];
      b_dig = b_reg[DIGIT_W*int'(j) +: DIGIT_W];
      pp_sh = '0;
      pp_sh[PP_W-1:0] = pp;
      pp_sh = pp_sh << (DIGIT_W * (int'(i) + int'(j)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         acc       <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         i         <= '0;
         j         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg    <= a;
                  b_reg    <= b;
                  acc      <= '0;
                  i        <= '0;
                  j        <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               acc <= acc + pp_sh;
               if (j == LAST) begin
                  j <= '0;
                  i <= i + 1'b1;
               end else begin
                  j <= j + 1'b1;
               end
               if (i == LAST && j == LAST) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign p = acc;

endmodule

// File: tb/tb_mul_digit_seq.sv
// Self-checking bench for mul_digit_seq: directed corner cases plus random operands
// checked against a plain a*b reference with a fixed D*D-cycle latency.
module tb_mul_digit_seq;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned D     = WIDTH / 2;
   localparam int unsigned LAT   = D * D;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] p;
   logic               busy;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   mul_digit_seq #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer operands and return once the accept edge has passed.
   task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input bit keep_valid, output int acc_cyc);
      int w;
      in_valid = 1'b1;
      a = av;
      b = bv;
      w = 0;
      while (!in_ready && w < 100) begin
         step();
         w++;
      end
      check("accept_wait", 32'(in_ready), 32'd1);
      step();
      acc_cyc = cyc;
      if (!keep_valid) in_valid = 1'b0;
   endtask

   // Wait for the result, verify latency/value, apply bp cycles of backpressure.
   task automatic collect(input string tag, input logic [2*WIDTH-1:0] exp,
                          input int bp, input bit poke_inputs);
      int lat;
      out_ready = (bp == 0);
      lat = 0;
      while (!out_valid && lat < 100) begin
         check({tag, "_busy"}, 32'(busy), 32'd1);
         check({tag, "_inrdy_run"}, 32'(in_ready), 32'd0);
         step();
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(LAT));
      check({tag, "_p"}, 32'(p), 32'(exp));
      for (int k = 0; k < bp; k++) begin
         if (poke_inputs) begin
            in_valid = 1'b1;
            a = 8'h77;
         end
         step();
         check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_hold_p"}, 32'(p), 32'(exp));
         check({tag, "_hold_inrdy"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      if (poke_inputs) in_valid = 1'b0;
      step();
      check({tag, "_idle_inrdy"}, 32'(in_ready), 32'd1);
      check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [WIDTH-1:0]   ra, rb;
      logic [2*WIDTH-1:0] rexp;
      int t0, t1;

      rst = 1'b1; in_valid = 1'b1; a = 8'hFF; b = 8'hFF; out_ready = 1'b1;
      step();
      step();
      check("rst_inrdy", 32'(in_ready), 32'd1);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_busy",  32'(busy), 32'd0);
      check("rst_p",     32'(p), 32'd0);
      rst = 1'b0; in_valid = 1'b0;
      step();
      check("post_rst_busy", 32'(busy), 32'd0);

      issue(8'hFF, 8'hFF, 1'b0, t0);
      collect("max", 16'hFE01, 0, 1'b0);
      issue(8'h00, 8'hA5, 1'b0, t0);
      collect("zero", 16'h0000, 0, 1'b0);
      issue(8'h01, 8'h01, 1'b0, t0);
      collect("one", 16'h0001, 0, 1'b0);

      issue(8'h12, 8'h34, 1'b0, t0);
      collect("bp", 16'h03A8, 5, 1'b1);

      // Reset arrives in cycle E0+7.
      issue(8'hC3, 8'h3C, 1'b0, t0);
      for (int k = 0; k < 6; k++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_inrdy", 32'(in_ready), 32'd1);
      check("midrst_busy",  32'(busy), 32'd0);
      issue(8'h03, 8'h07, 1'b0, t0);
      collect("after_rst", 16'h0015, 0, 1'b0);

      out_ready = 1'b1;
      issue(8'h12, 8'h34, 1'b1, t0);
      a = 8'hC3; b = 8'h3C;
      collect("b2b1", 16'h03A8, 0, 1'b0);
      in_valid = 1'b1;
      step();
      t1 = cyc;
      in_valid = 1'b0;
      check("b2b_interval", 32'(t1 - t0), 32'(LAT + 2));
      collect("b2b2", 16'h2DB4, 0, 1'b0);

      for (int n = 0; n < 24; n++) begin
         ra = WIDTH'($urandom_range(0, 255));
         rb = WIDTH'($urandom_range(0, 255));
         rexp = (2*WIDTH)'(int'(ra) * int'(rb));
         issue(ra, rb, 1'b0, t0);
         collect("rand", rexp, int'($urandom_range(0, 3)), 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
